// File: rtl/inst_mem_arbiter_pkg.sv
// Shared encodings and widths for the instruction-memory boot sequencer/arbiter.
package inst_mem_arbiter_pkg;

  localparam int INST_ADDR_BUS    = 32;
  localparam int INST_BUS         = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } mode_e;

endpackage

// File: rtl/inst_mem_arbiter_starve_cnt.sv
// Saturating count of consecutive CPU grants taken while the loader waits.
module arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  assign o_sat = (r_cnt == CW'(LIMIT));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Holds the CPU in reset while the loader fills instruction memory, then arbitrates
// the single memory port between fetch (priority) and loader (starvation-bounded).
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int DEPTH_LOG2   = 10,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_ce_i,
  input  logic [INST_ADDR_BUS-1:0] cpu_addr_i,
  output logic [INST_BUS-1:0]      cpu_inst_o,
  output logic                     cpu_stall_o,
  output logic                     cpu_rst_o,
  input  logic                     ldr_req_i,
  input  logic                     ldr_we_i,
  input  logic [DEPTH_LOG2-1:0]    ldr_addr_i,
  input  logic [INST_BUS-1:0]      ldr_wdata_i,
  input  logic                     ldr_done_i,
  output logic                     ldr_ack_o,
  output logic [INST_BUS-1:0]      ldr_rdata_o,
  output logic                     mem_ce_o,
  output logic                     mem_we_o,
  output logic [DEPTH_LOG2-1:0]    mem_addr_o,
  output logic [INST_BUS-1:0]      mem_wdata_o,
  input  logic [INST_BUS-1:0]      mem_rdata_i
);

  mode_e               r_mode;
  logic                r_done_seen;
  logic                r_ldr_pend;
  logic                r_cpu_rd;
  logic [INST_BUS-1:0] r_hold;

  logic w_ldr_elig;
  logic w_gnt_cpu;
  logic w_gnt_ldr;
  logic w_sat;
  logic w_unused_addr;

  assign w_unused_addr = ^{cpu_addr_i[INST_ADDR_BUS-1:DEPTH_LOG2+2], cpu_addr_i[1:0]};
  assign w_ldr_elig    = ldr_req_i && !r_ldr_pend;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_gnt_cpu = 1'b0;
    w_gnt_ldr = 1'b0;
    if (r_mode == BOOT) begin
      w_gnt_ldr = w_ldr_elig;
    end else if (cpu_ce_i && !w_sat) begin
      w_gnt_cpu = 1'b1;
    end else if (w_ldr_elig) begin
      w_gnt_ldr = 1'b1;
    end else begin
      w_gnt_cpu = cpu_ce_i;
    end
  end

  always_comb begin
    mem_ce_o    = w_gnt_cpu || w_gnt_ldr;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_gnt_cpu) begin
      mem_addr_o = cpu_addr_i[DEPTH_LOG2+1:2];
    end else if (w_gnt_ldr) begin
      mem_we_o    = ldr_we_i;
      mem_addr_o  = ldr_addr_i;
      mem_wdata_o = ldr_wdata_i;
    end
  end

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_inc (w_gnt_cpu && w_ldr_elig),
    .i_clr (w_gnt_ldr || !w_ldr_elig),
    .o_sat (w_sat)
  );

  // A done pulse that lands on a loader grant is remembered until that access acks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode      <= BOOT;
      r_done_seen <= 1'b0;
    end else if (r_mode == BOOT) begin
      if ((ldr_done_i || r_done_seen) && !w_gnt_ldr) begin
        r_mode      <= RUN;
        r_done_seen <= 1'b0;
      end else if (ldr_done_i) begin
        r_done_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ldr_pend <= 1'b0;
      r_cpu_rd   <= 1'b0;
      r_hold     <= '0;
    end else begin
      r_ldr_pend <= w_gnt_ldr;
      r_cpu_rd   <= w_gnt_cpu;
      if (r_cpu_rd) begin
        r_hold <= mem_rdata_i;
      end
    end
  end

  assign cpu_rst_o   = (r_mode == BOOT);
  assign cpu_stall_o = (r_mode == BOOT) || (cpu_ce_i && !w_gnt_cpu);
  assign cpu_inst_o  = r_cpu_rd ? mem_rdata_i : r_hold;
  assign ldr_ack_o   = r_ldr_pend;
  assign ldr_rdata_o = r_ldr_pend ? mem_rdata_i : '0;

endmodule

// File: doc/inst_mem_arbiter.md
# inst_mem_arbiter

Boot-sequencing controller and arbiter for the single-port synchronous instruction memory in the minimal SOPC. It sits between the openmips fetch port, a host loader port, and the memory array. After reset it holds the CPU in reset while the loader fills memory. Once the loader signals completion it releases the CPU and shares the memory port between fetch (priority) and loader (starvation-protected).

## Interface

**Parameters**
- DEPTH_LOG2, default 10: memory word-address width; 2^DEPTH_LOG2 words of 32 bits.
- STARVE_LIMIT, default 4: maximum number of consecutive CPU grants while a loader request waits.

**Ports**
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_ce_i  in  1  fetch request (openmips rom_ce).
- cpu_addr_i  in  32  fetch byte address; word index is bits [DEPTH_LOG2+1:2].
- cpu_inst_o  out  32  fetched instruction.
- cpu_stall_o  out  1  fetch not granted this cycle; the CPU holds its address.
- cpu_rst_o  out  1  active-high reset to openmips.
- ldr_req_i  in  1  loader access request; held until ack.
- ldr_we_i  in  1  1 = write, 0 = read.
- ldr_addr_i  in  DEPTH_LOG2  loader word address.
- ldr_wdata_i  in  32  write data.
- ldr_done_i  in  1  single-cycle pulse: image load complete.
- ldr_ack_o  out  1  one-cycle completion pulse.
- ldr_rdata_o  out  32  read data; valid while ldr_ack_o is high.
- mem_ce_o, mem_we_o  out  1  memory enable and write strobe.
- mem_addr_o  out  DEPTH_LOG2  memory word address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  read data; valid one cycle after mem_ce_o.

## Operation

**Mode FSM**
- BOOT (reset state): cpu_rst_o=1, cpu_stall_o=1. Only the loader is served.
- BOOT -> RUN on ldr_done_i, provided no loader access is pending. If one is pending, the FSM moves at its ack.
- RUN: cpu_rst_o=0. RUN is left only by reset.

**Grant (combinational, per cycle)**
- The loader is eligible when ldr_req_i=1 and ldr_pend_q=0.
- BOOT: grant the loader if eligible.
- RUN:
  - If cpu_ce_i=1 and starve_cnt<STARVE_LIMIT, grant the CPU.
  - Otherwise, if the loader is eligible, grant the loader.
  - Otherwise, if cpu_ce_i=1, grant the CPU.
- The memory is driven in the same cycle as the grant: mem_ce_o=1, and address/data/we come from the granted side. When neither side is granted, mem_ce_o=0 and the other memory outputs are 0. CPU grants have mem_we_o=0.

**Starvation counter (starve_cnt)**
- Increments on a CPU grant while the loader is eligible, saturating at STARVE_LIMIT.
- Clears on a loader grant, and in any cycle in which the loader is not eligible.

**Loader transaction**
- ldr_pend_q is set on the edge after a loader grant.
- ldr_ack_o = ldr_pend_q, and ldr_rdata_o = mem_rdata_i while ldr_ack_o is high (0 otherwise).
- ldr_pend_q clears after one cycle. A new request is granted no earlier than the cycle after ack.

**Fetch data**
- cpu_rd_q is the registered CPU grant.
- cpu_inst_o = cpu_rd_q ? mem_rdata_i : hold_q.
- hold_q captures mem_rdata_i whenever cpu_rd_q=1, so cpu_inst_o is stable across stalls.

**Stall**
- cpu_stall_o = BOOT, or (cpu_ce_i=1 and no CPU grant).

## Timing

**Reset values** (asynchronous on rst=0)
- State = BOOT.
- cpu_rst_o=1, cpu_stall_o=1, cpu_inst_o=0.
- ldr_ack_o=0, ldr_rdata_o=0.
- mem_ce_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Internal registers hold_q, starve_cnt, ldr_pend_q, cpu_rd_q all 0.

**Latency**
- Fetch: address in cycle N, data on cpu_inst_o in N+1.
- Loader: granted in N, ack (and read data) in N+1. Minimum loader period is 2 cycles.

**Release**
- If ldr_done_i arrives in cycle N with nothing pending, cpu_rst_o falls at edge N+1. The first fetch can be granted in N+1.

**Boundary conditions**
- ldr_done_i in the same cycle as a loader grant: the grant completes (ack in N+1), then the FSM enters RUN.
- Reset mid-transaction: a pending ack is dropped and the FSM returns to BOOT. The memory contents are not touched.
- A loader request in RUN with cpu_ce_i=0 is granted immediately.
- The CPU address is truncated to the memory depth; out-of-range addresses wrap.

## Structure

**Shared defines file**
- Mode encodings: BOOT=1'b0, RUN=1'b1.
- `InstAddrBus and `InstBus widths.
- Default STARVE_LIMIT.

**Sub-module**
- Natural: arb_starve_cnt, a saturating counter with inc, clr and sat outputs.
- The FSM, grant mux, and hold/pending registers stay in the top module.

## Test plan

1. **Reset and boot writes.** Hold rst=0, then release. Issue loader writes of 0x11111111 to word 0 and 0x22222222 to word 1.
   - Required: cpu_rst_o=1 and cpu_stall_o=1 throughout.
   - Each ack arrives exactly 1 cycle after its grant, and the second grant comes 2 cycles after the first.
2. **Release and fetch.** Pulse ldr_done_i, then fetch with cpu_addr_i=0x4 and cpu_ce_i held high.
   - Required: cpu_rst_o falls at the next edge.
   - cpu_inst_o=0x22222222 one cycle after the grant.
   - Stall stays 0 while the loader is idle.
3. **Starvation bound.** In RUN, hold cpu_ce_i=1 and ldr_req_i=1 (read of word 0).
   - Required: 4 CPU grants, then 1 loader grant (cpu_stall_o=1 for that cycle).
   - ack follows with ldr_rdata_o=0x11111111.
   - cpu_inst_o holds its previous value during the stall.
4. **Done with a pending access.** Assert ldr_done_i in the same cycle as a loader grant.
   - Required: ack in N+1, and RUN entered with no lost access.
5. **Reset mid-transaction.** Assert rst=0 in the cycle after a loader grant.
   - Required: ldr_ack_o=0 immediately, state BOOT, cpu_rst_o=1.
6. **Address wrap.** With DEPTH_LOG2=10, fetch cpu_addr_i=0x1004.
   - Required: mem_addr_o=1.
